// File: rtl/int_pkg.sv
// Shared types and default parameters for the nested interrupt controller.
package int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_RETURN = 2'd2
    } int_state_e;

    localparam int          NSRC_DEF       = 4;
    localparam int          DEPTH_DEF      = 4;
    localparam int          AW_DEF         = 32;
    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
    localparam int          VEC_STRIDE_DEF = 16;
    localparam int          LVL_W          = 5;
    localparam int          DEP_W          = 4;

endpackage

// File: rtl/int_prio_enc.sv
// Highest-index-first priority encoder with a valid flag.
module int_prio_enc
    import int_pkg::*;
#(
    parameter int N = NSRC_DEF
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [3:0]   idx_o
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl_nest.sv
// Nested vectored interrupt controller: priority entry, EPC/level stack and eret return.
module int_ctrl_nest
    import int_pkg::*;
#(
    parameter int          NSRC       = NSRC_DEF,
    parameter int          DEPTH      = DEPTH_DEF,
    parameter int          AW         = AW_DEF,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int          VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic [NSRC-1:0]   in_req,
    input  logic [NSRC-1:0]   in_mask,
    input  logic              in_IE,
    input  logic              in_eret,
    input  logic [AW-1:0]     in_EPC,
    input  logic              in_FDCLR,
    input  logic              in_DECLR,
    output logic              R_FDCLR,
    output logic              R_DECLR,
    output logic              R_EECLR,
    output logic              out_force,
    output logic [AW-1:0]     out_pc,
    output logic [NSRC-1:0]   out_ack,
    output logic [LVL_W-1:0]  out_level,
    output logic [DEP_W-1:0]  out_depth,
    output logic              out_err
);

    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    int_state_e        state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [AW-1:0]     epc_q, epc_d;
    logic [AW-1:0]     ret_pc_q, ret_pc_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DEP_W-1:0]  depth_q, depth_d;
    logic              err_q, err_d;
    logic              push;

    logic [AW-1:0]     epc_stk_q [DEPTH];
    logic [LVL_W-1:0]  lvl_stk_q [DEPTH];
    logic [SW-1:0]     wr_idx, rd_idx;

    logic [NSRC-1:0]   elig;
    logic              enc_valid;
    logic [3:0]        enc_idx;

    assign wr_idx = SW'(depth_q);
    assign rd_idx = SW'(depth_q - DEP_W'(1));

    // Only sources strictly above the current level may preempt, and only with stack room.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NSRC; k++) begin
            elig[k] = in_req[k] & ~in_mask[k] & in_IE &
                      (LVL_W'(k + 1) > level_q) & (depth_q < DEP_W'(DEPTH));
        end
    end

    int_prio_enc #(.N(NSRC)) u_enc (
        .req_i   (elig),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        epc_d    = epc_q;
        ret_pc_d = ret_pc_q;
        level_d  = level_q;
        depth_d  = depth_q;
        err_d    = 1'b0;
        push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_eret) begin
                    if (depth_q != '0) begin
                        state_d  = ST_RETURN;
                        depth_d  = depth_q - DEP_W'(1);
                        level_d  = lvl_stk_q[rd_idx];
                        ret_pc_d = epc_stk_q[rd_idx];
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (enc_valid) begin
                    state_d = ST_ENTER;
                    k_d     = enc_idx;
                    epc_d   = in_EPC;
                end
            end
            ST_ENTER: begin
                state_d = ST_IDLE;
                push    = 1'b1;
                level_d = LVL_W'(k_q) + LVL_W'(1);
                depth_d = depth_q + DEP_W'(1);
            end
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            epc_q    <= '0;
            ret_pc_q <= '0;
            level_q  <= '0;
            depth_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            epc_q    <= epc_d;
            ret_pc_q <= ret_pc_d;
            level_q  <= level_d;
            depth_q  <= depth_d;
            err_q    <= err_d;
        end
    end

    // Stack contents are meaningless once depth is reset, so no reset here.
    always_ff @(posedge in_CLK) begin
        if (push) begin
            epc_stk_q[wr_idx] <= epc_q;
            lvl_stk_q[wr_idx] <= level_q;
        end
    end

    always_comb begin
        out_force = 1'b0;
        out_pc    = in_EPC;
        out_ack   = '0;
        R_FDCLR   = in_FDCLR;
        R_DECLR   = in_DECLR;
        R_EECLR   = 1'b0;
        case (state_q)
            ST_ENTER: begin
                out_force = 1'b1;
                out_pc    = AW'(VEC_BASE) + AW'(k_q) * AW'(VEC_STRIDE);
                out_ack   = NSRC'(1) << k_q;
                R_FDCLR   = 1'b1;
                R_DECLR   = 1'b1;
                R_EECLR   = 1'b1;
            end
            ST_RETURN: begin
                out_force = 1'b1;
                out_pc    = ret_pc_q;
                R_FDCLR   = 1'b1;
                R_DECLR   = 1'b1;
                R_EECLR   = 1'b1;
            end
            default: ;
        endcase
        if (in_RST) begin
            out_pc  = '0;
            R_FDCLR = 1'b1;
            R_DECLR = 1'b1;
            R_EECLR = 1'b1;
        end
    end

    assign out_level = level_q;
    assign out_depth = depth_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_int_ctrl_nest.sv
// Scoreboard bench for int_ctrl_nest: directed vectors, force events checked by a monitor.
module tb_int_ctrl_nest;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  mask = '0;
    logic        ie = 1'b1;
    logic        eret = 1'b0;
    logic [31:0] epc = 32'h55;
    logic        fdclr = 1'b0;
    logic        declr = 1'b0;
    logic        r_fd, r_de, r_ee, frc, err;
    logic [31:0] pc;
    logic [3:0]  ack;
    logic [4:0]  lvl;
    logic [3:0]  dep;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  ack;
        logic [4:0]  lvl;
    } exp_t;
    exp_t sbq[$];

    int_ctrl_nest #(.NSRC(4), .DEPTH(2), .AW(32), .VEC_BASE(32'h100), .VEC_STRIDE(16)) dut (
        .in_CLK(clk), .in_RST(rst), .in_req(req), .in_mask(mask), .in_IE(ie),
        .in_eret(eret), .in_EPC(epc), .in_FDCLR(fdclr), .in_DECLR(declr),
        .R_FDCLR(r_fd), .R_DECLR(r_de), .R_EECLR(r_ee), .out_force(frc),
        .out_pc(pc), .out_ack(ack), .out_level(lvl), .out_depth(dep), .out_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_force(input logic [31:0] p, input logic [3:0] a, input logic [4:0] l);
        exp_t e;
        e.pc = p; e.ack = a; e.lvl = l;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && frc) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_force: pc=%0h ack=%0h", pc, ack);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("force_pc", pc, e.pc);
                chk("force_ack", ack, e.ack);
                chk("force_level", lvl, e.lvl);
                chk("force_clears", {r_fd, r_de, r_ee}, 3'b111);
            end
        end
    end

    initial begin
        #12;
        chk("rst_force", frc, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ack", ack, 0);
        chk("rst_clears", {r_fd, r_de, r_ee}, 3'b111);
        chk("rst_level", lvl, 0);
        chk("rst_depth", dep, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();

        fdclr = 1'b1; declr = 1'b0; #1;
        chk("idle_pass_fd", {r_fd, r_de, r_ee}, 3'b100);
        fdclr = 1'b0; declr = 1'b1; #1;
        chk("idle_pass_de", {r_fd, r_de, r_ee}, 3'b010);
        declr = 1'b0;

        // single entry / return
        req = 4'b0010; epc = 32'h40;
        expect_force(32'h110, 4'b0010, 5'd0);
        tick();
        chk("enter_latency", frc, 1);
        req = '0;
        tick();
        chk("single_level", lvl, 2);
        chk("single_depth", dep, 1);
        eret = 1'b1;
        expect_force(32'h40, 4'b0000, 5'd0);
        tick();
        eret = 1'b0;
        tick();
        chk("single_ret_level", lvl, 0);
        chk("single_ret_depth", dep, 0);

        // nesting 1 -> 3
        req = 4'b0010; epc = 32'h40;
        expect_force(32'h110, 4'b0010, 5'd0);
        tick(); tick();
        req = 4'b1010; epc = 32'h200;
        expect_force(32'h130, 4'b1000, 5'd2);
        tick(); tick();
        req = '0;
        chk("nest_level", lvl, 4);
        chk("nest_depth", dep, 2);
        eret = 1'b1;
        expect_force(32'h200, 4'b0000, 5'd2);
        tick(); eret = 1'b0; tick();
        chk("nest_ret1_level", lvl, 2);
        eret = 1'b1;
        expect_force(32'h40, 4'b0000, 5'd0);
        tick(); eret = 1'b0; tick();
        chk("nest_ret2_level", lvl, 0);
        chk("nest_ret2_depth", dep, 0);

        // no preemption by lower priority
        req = 4'b1000; epc = 32'h300;
        expect_force(32'h130, 4'b1000, 5'd0);
        tick(); tick();
        req = 4'b0001;
        tick(); tick(); tick();
        chk("nopre_level", lvl, 4);
        chk("nopre_depth", dep, 1);
        eret = 1'b1; epc = 32'h310;
        expect_force(32'h300, 4'b0000, 5'd0);
        expect_force(32'h100, 4'b0001, 5'd0);
        tick();
        eret = 1'b0;
        chk("nopre_ret_force", frc, 1);
        tick();
        chk("nopre_idle_gap", frc, 0);
        chk("nopre_restored", lvl, 0);
        tick();
        chk("nopre_enter_force", frc, 1);
        req = '0;
        tick();
        chk("nopre_src0_level", lvl, 1);
        eret = 1'b1;
        expect_force(32'h310, 4'b0000, 5'd0);
        tick(); eret = 1'b0; tick();

        // simultaneous eret and request
        req = 4'b0010; epc = 32'h40;
        expect_force(32'h110, 4'b0010, 5'd0);
        tick(); tick();
        req = 4'b1000; eret = 1'b1; epc = 32'h500;
        expect_force(32'h40, 4'b0000, 5'd0);
        expect_force(32'h130, 4'b1000, 5'd0);
        tick(); eret = 1'b0;
        tick(); tick(); tick();
        req = '0;
        chk("simul_level", lvl, 4);
        chk("simul_depth", dep, 1);
        eret = 1'b1;
        expect_force(32'h500, 4'b0000, 5'd0);
        tick(); eret = 1'b0; tick();

        // stack full: third request held pending
        req = 4'b0001; epc = 32'h10;
        expect_force(32'h100, 4'b0001, 5'd0);
        tick(); tick();
        req = 4'b0011; epc = 32'h20;
        expect_force(32'h110, 4'b0010, 5'd1);
        tick(); tick();
        req = 4'b1011; epc = 32'h30;
        tick(); tick(); tick();
        chk("full_depth", dep, 2);
        chk("full_level", lvl, 2);
        eret = 1'b1;
        expect_force(32'h20, 4'b0000, 5'd1);
        expect_force(32'h130, 4'b1000, 5'd1);
        tick(); eret = 1'b0;
        tick(); tick(); tick();
        req = '0;
        chk("pending_level", lvl, 4);
        chk("pending_depth", dep, 2);
        eret = 1'b1;
        expect_force(32'h30, 4'b0000, 5'd1);
        tick(); eret = 1'b0; tick();
        eret = 1'b1;
        expect_force(32'h10, 4'b0000, 5'd0);
        tick(); eret = 1'b0; tick();
        chk("unwind_depth", dep, 0);

        // eret underflow
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("uflow_err", err, 1);
        chk("uflow_force", frc, 0);
        chk("uflow_depth", dep, 0);
        tick();
        chk("uflow_err_pulse", err, 0);

        // masked and globally disabled requests
        req = 4'b0100; mask = 4'b0100;
        tick(); tick();
        mask = '0; ie = 1'b0;
        tick(); tick();
        chk("gated_depth", dep, 0);
        req = '0; ie = 1'b1;
        tick();

        // reset during a nested ENTER
        req = 4'b0001; epc = 32'h70;
        expect_force(32'h100, 4'b0001, 5'd0);
        tick(); tick();
        req = 4'b0101; epc = 32'h80;
        expect_force(32'h120, 4'b0100, 5'd1);
        tick();
        @(negedge clk);
        #1;
        rst = 1'b1; req = '0;
        #1;
        chk("midrst_force", frc, 0);
        chk("midrst_pc", pc, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_clears", {r_fd, r_de, r_ee}, 3'b111);
        chk("midrst_level", lvl, 0);
        chk("midrst_depth", dep, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("postrst_level", lvl, 0);
        chk("postrst_depth", dep, 0);
        chk("postrst_force", frc, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_ctrl_nest.md
INT_CTRL_NEST -- requirements
Module: int_ctrl_nest

Interface
REQ-001 Parameters (name, default, meaning): NSRC, 4, interrupt source count (2..16); DEPTH, 4, nesting/EPC stack depth (1..8); AW, 32, address width; VEC_BASE, 32'h0000_0100, vector table base; VEC_STRIDE, 16, bytes per vector.
REQ-002 Ports (name, direction, width, meaning); reset in_RST, asynchronous, active-high; clock in_CLK:
- in_CLK  in  1  clock
- in_RST  in  1  async reset, active-high
- in_req  in  NSRC  level requests, bit k = source k
- in_mask  in  NSRC  1 = source disabled
- in_IE  in  1  global interrupt enable
- in_eret  in  1  eret in execute stage, single-cycle pulse
- in_EPC  in  AW  resume PC supplied by pipeline
- in_FDCLR / in_DECLR  in  1  hazard-unit flush requests
- R_FDCLR / R_DECLR / R_EECLR  out  1  stage-register clears
- out_force  out  1  PC override strobe
- out_pc  out  AW  override target
- out_ack  out  NSRC  one-hot entry acknowledge
- out_level  out  5  current service level (0 = none, k+1 = source k)
- out_depth  out  4  stack occupancy
- out_err  out  1  eret-underflow pulse

Function
REQ-003 Priority: higher source index = higher priority; level of source k = k+1.
REQ-004 Eligible request: in_req[k] & ~in_mask[k] & in_IE & (k+1 > out_level) & (out_depth < DEPTH).
REQ-005 FSM states IDLE, ENTER, RETURN; ENTER and RETURN each last exactly one cycle, then IDLE.
REQ-006 IDLE -> ENTER on a clock edge with an eligible request and in_eret low; the highest eligible k is latched.
REQ-007 During ENTER: out_force=1; out_pc=VEC_BASE+k*VEC_STRIDE; R_FDCLR=R_DECLR=R_EECLR=1; out_ack[k]=1 (one cycle only).
REQ-008 ENTER edge: push {in_EPC sampled at the IDLE->ENTER edge, previous out_level}; out_level becomes k+1; out_depth increments.
REQ-009 IDLE -> RETURN on a clock edge with in_eret high and out_depth>0; top entry is popped at that edge.
REQ-010 During RETURN: out_force=1; out_pc=popped EPC; all three clears=1; out_level=popped level.
REQ-011 In IDLE: out_force=0; out_ack=0; R_FDCLR=in_FDCLR; R_DECLR=in_DECLR; R_EECLR=0; out_pc=in_EPC (don't-care).
REQ-012 in_eret and eligible request on the same edge: eret wins. The request is re-evaluated in the cycle after RETURN against the restored level.
REQ-013 in_eret with out_depth=0: no state change, no force; out_err=1 for one cycle.
REQ-014 Stack full (out_depth=DEPTH): no request is eligible; requests stay pending, not dropped.
REQ-015 Inputs are ignored in ENTER/RETURN, except in_RST.
REQ-016 Latency: out_force asserts exactly one cycle after the edge that samples the eligible request or eret.
REQ-017 Masking or deasserting a request after the IDLE->ENTER edge does not cancel the entry.

Reset
REQ-018 While in_RST is high: state=IDLE; out_level=0; out_depth=0; stack contents invalid; out_force=0; out_ack=0; out_err=0; out_pc=0.
REQ-019 While in_RST is high: R_FDCLR=R_DECLR=R_EECLR=1.
REQ-020 Reset asserted during ENTER/RETURN aborts the transfer; no partial push/pop is retained.

Structure
REQ-021 Shared package int_pkg holds: FSM state enum; defaults for NSRC, DEPTH, AW, VEC_BASE, VEC_STRIDE; level-width constant.
REQ-022 One sub-module int_prio_enc (NSRC-wide, highest-index-first encoder with valid output); stack and FSM stay in int_ctrl_nest.

Verification
REQ-023 Single entry/return: in_req=4'b0010, level 0, in_EPC=0x40 -> next cycle out_force=1, out_pc=0x110, out_ack=0010, then level=2. Later eret -> out_pc=0x40, level=0.
REQ-024 Nesting: during source-1 service, assert source 3 with in_EPC=0x200 -> out_pc=0x130, depth=2. Two erets return to 0x200 then the original EPC, with levels 2 then 0.
REQ-025 No preemption by lower/equal priority: at level 4, raise source 0 -> no force until eret. Then level 0 and source 0 enters on the cycle after RETURN.
REQ-026 Simultaneous eret + request at depth 1 -> RETURN first. ENTER the following cycle if still eligible.
REQ-027 Boundaries: DEPTH=2, third nested request blocked (depth stays 2); eret at depth 0 -> out_err pulse, no out_force.
REQ-028 in_RST asserted mid-ENTER -> all outputs at reset values and all clears=1; after release, depth=0 and level=0.
